// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Write-back scheduler for the single register-file write port. The ALU
// write-back path (valid/ready) and the LSU load-return path (no back-pressure,
// buffered in a small circular FIFO) share one registered write port. Writes to
// x0 are granted but never enabled.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   hold_i             pipeline freeze: no pops and no ALU grants while high
//   alu_valid_i/rd/data ALU write-back request; alu_ready_o is the handshake
//   lsu_valid_i/rd/data load-return push into the FIFO
//   wr_port_o/wr_data_o/ctrl_reg_wr_en_o  registered register-file write port
//   lsu_overflow_o     sticky: a load return was dropped on a full FIFO
module wb_port_arbiter #(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic [4:0]  wr_port_o,
  output logic [31:0] wr_data_o,
  output logic        ctrl_reg_wr_en_o,
  output logic        lsu_overflow_o
);

  localparam int         DATA_W     = 32;
  localparam int         RD_W       = 5;
  localparam int         PTR_W      = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  // Saturating increment of the starvation counter.
  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + 3'd1;
  endfunction

  logic [RD_W-1:0]   fifo_rd   [LSU_DEPTH];
  logic [DATA_W-1:0] fifo_data [LSU_DEPTH];

  // Pointers carry one extra wrap bit so full and empty differ.
  logic [PTR_W:0]    wr_ptr_p0;
  logic [PTR_W:0]    rd_ptr_p0;
  logic [2:0]        starve_cnt_p0;

  logic [RD_W-1:0]   wr_port_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic              vld_p1;
  logic              overflow_p1;

  logic              fifo_empty;
  logic              fifo_full;
  logic              alu_force;
  logic              lsu_grant;
  logic              alu_grant;
  logic              push_ok;
  logic              push_drop;
  logic [RD_W-1:0]   head_rd;
  logic [DATA_W-1:0] head_data;

  // ---- Stage p0: grant decision from FIFO head, ALU request and starvation state
  assign fifo_empty = (wr_ptr_p0 == rd_ptr_p0);
  assign fifo_full  = (wr_ptr_p0[PTR_W] != rd_ptr_p0[PTR_W]) &&
                      (wr_ptr_p0[PTR_W-1:0] == rd_ptr_p0[PTR_W-1:0]);
  assign head_rd    = fifo_rd[rd_ptr_p0[PTR_W-1:0]];
  assign head_data  = fifo_data[rd_ptr_p0[PTR_W-1:0]];

  assign alu_force  = alu_valid_i && (starve_cnt_p0 == STARVE_MAX);
  assign lsu_grant  = !hold_i && !fifo_empty && !alu_force;
  assign alu_grant  = !hold_i && alu_valid_i && (fifo_empty || alu_force);
  assign alu_ready_o = alu_grant;

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign push_ok    = lsu_valid_i && (!fifo_full || lsu_grant);
  assign push_drop  = lsu_valid_i && fifo_full && !lsu_grant;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_rd[wr_ptr_p0[PTR_W-1:0]]   <= lsu_rd_i;
      fifo_data[wr_ptr_p0[PTR_W-1:0]] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0     <= '0;
      rd_ptr_p0     <= '0;
      starve_cnt_p0 <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_p0 <= wr_ptr_p0 + (PTR_W+1)'(1);
      end
      if (lsu_grant) begin
        rd_ptr_p0 <= rd_ptr_p0 + (PTR_W+1)'(1);
      end
      if (!hold_i) begin
        if (!alu_valid_i || alu_grant) begin
          starve_cnt_p0 <= '0;
        end else begin
          starve_cnt_p0 <= sat_inc(starve_cnt_p0);
        end
      end
    end
  end

  // ---- Stage p1: registered register-file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_port_p1  <= '0;
      wr_data_p1  <= '0;
      vld_p1      <= 1'b0;
      overflow_p1 <= 1'b0;
    end else begin
      if (lsu_grant) begin
        wr_port_p1 <= head_rd;
        wr_data_p1 <= head_data;
        vld_p1     <= (head_rd != '0);
      end else if (alu_grant) begin
        wr_port_p1 <= alu_rd_i;
        wr_data_p1 <= alu_data_i;
        vld_p1     <= (alu_rd_i != '0);
      end else begin
        vld_p1     <= 1'b0;
      end
      if (push_drop) begin
        overflow_p1 <= 1'b1;
      end
    end
  end

  assign wr_port_o        = wr_port_p1;
  assign wr_data_o        = wr_data_p1;
  assign ctrl_reg_wr_en_o = vld_p1;
  assign lsu_overflow_o   = overflow_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  wr_port;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        lsu_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.LSU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hold_i           (hold),
    .alu_valid_i      (alu_valid),
    .alu_rd_i         (alu_rd),
    .alu_data_i       (alu_data),
    .alu_ready_o      (alu_ready),
    .lsu_valid_i      (lsu_valid),
    .lsu_rd_i         (lsu_rd),
    .lsu_data_i       (lsu_data),
    .wr_port_o        (wr_port),
    .wr_data_o        (wr_data),
    .ctrl_reg_wr_en_o (wr_en),
    .lsu_overflow_o   (lsu_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending loads plus the registered write port.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve = 0;
  logic [4:0]  m_port   = '0;
  logic [31:0] m_data   = '0;
  logic        m_en     = 1'b0;
  logic        m_ovf    = 1'b0;

  // Inputs change 2 time units after the rising edge, so at the falling edge
  // they hold the values the next rising edge will consume.
  always @(negedge clk) begin
    bit   force_alu;
    bit   exp_ready;
    bit   g_lsu;
    bit   g_alu;
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_starve = 0;
      m_port   = '0;
      m_data   = '0;
      m_en     = 1'b0;
      m_ovf    = 1'b0;
    end
    force_alu = alu_valid && (m_starve == LIMIT);
    exp_ready = !hold && alu_valid && ((m_q.size() == 0) || force_alu);
    check("model_alu_ready", {31'd0, alu_ready}, {31'd0, exp_ready});
    check("model_wr_en", {31'd0, wr_en}, {31'd0, m_en});
    check("model_wr_port", {27'd0, wr_port}, {27'd0, m_port});
    check("model_wr_data", wr_data, m_data);
    check("model_overflow", {31'd0, lsu_overflow}, {31'd0, m_ovf});
    if (rst_n) begin
      g_lsu = !hold && (m_q.size() > 0) && !force_alu;
      g_alu = !hold && !g_lsu && alu_valid;
      if (g_lsu) begin
        e      = m_q.pop_front();
        m_port = e.rd;
        m_data = e.data;
        m_en   = (e.rd != 5'd0);
      end else if (g_alu) begin
        m_port = alu_rd;
        m_data = alu_data;
        m_en   = (alu_rd != 5'd0);
      end else begin
        m_en   = 1'b0;
      end
      if (lsu_valid) begin
        if (m_q.size() < DEPTH) begin
          e.rd   = lsu_rd;
          e.data = lsu_data;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (!hold) begin
        if (!alu_valid || g_alu) m_starve = 0;
        else if (m_starve < LIMIT) m_starve = m_starve + 1;
      end
    end
  end

  task automatic set_in(input logic h, input logic av, input logic [4:0] ard,
                        input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                        input logic [31:0] ld);
    hold      = h;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic starve_ready [7];

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // ALU only: handshake in N, write in N+1
    set_in(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    #1 check("alu_only_ready", {31'd0, alu_ready}, 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 check("alu_only_en", {31'd0, wr_en}, 32'd1);
    check("alu_only_port", {27'd0, wr_port}, 32'd5);
    check("alu_only_data", wr_data, 32'hDEADBEEF);
    step();
    #1 check("alu_only_en_drop", {31'd0, wr_en}, 32'd0);

    // Contention: LSU entry first, then the ALU once the FIFO is empty
    set_in(0, 0, 0, 0, 1, 5'd3, 32'h11);
    step();
    set_in(0, 1, 5'd4, 32'h22, 0, 0, 0);
    #1 check("cont_c1_ready", {31'd0, alu_ready}, 32'd0);
    step();
    #1 check("cont_c2_ready", {31'd0, alu_ready}, 32'd1);
    check("cont_c2_en", {31'd0, wr_en}, 32'd1);
    check("cont_c2_port", {27'd0, wr_port}, 32'd3);
    check("cont_c2_data", wr_data, 32'h11);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 check("cont_c3_en", {31'd0, wr_en}, 32'd1);
    check("cont_c3_port", {27'd0, wr_port}, 32'd4);
    check("cont_c3_data", wr_data, 32'h22);
    step();
    step();

    // Starvation: LSU pushes every cycle, ALU valid from cycle 1
    starve_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      set_in(0, (i >= 1), 5'd9, 32'h99, 1, 5'(20 + i), 32'h200 + 32'(i));
      #1 check($sformatf("starve_c%0d_ready", i), {31'd0, alu_ready}, {31'd0, starve_ready[i]});
      if (i == 6) check("starve_ovf_before", {31'd0, lsu_overflow}, 32'd0);
      step();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1 check("starve_ovf_after", {31'd0, lsu_overflow}, 32'd1);
    step();

    // Reset mid-stream with two entries still queued
    rst_n = 1'b0;
    #1 check("rst_en", {31'd0, wr_en}, 32'd0);
    check("rst_port", {27'd0, wr_port}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_ovf", {31'd0, lsu_overflow}, 32'd0);
    check("rst_ready", {31'd0, alu_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check($sformatf("post_rst_en_%0d", i), {31'd0, wr_en}, 32'd0);
    end

    // Overflow under hold
    set_in(1, 0, 0, 0, 1, 5'd10, 32'h100);
    step();
    set_in(1, 0, 0, 0, 1, 5'd11, 32'h101);
    step();
    set_in(1, 0, 0, 0, 1, 5'd12, 32'h102);
    #1 check("ovf_before_drop", {31'd0, lsu_overflow}, 32'd0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1 check("ovf_set", {31'd0, lsu_overflow}, 32'd1);
    check("ovf_hold_en", {31'd0, wr_en}, 32'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    #1 check("ovf_w1_en", {31'd0, wr_en}, 32'd1);
    check("ovf_w1_port", {27'd0, wr_port}, 32'd10);
    check("ovf_w1_data", wr_data, 32'h100);
    step();
    #1 check("ovf_w2_en", {31'd0, wr_en}, 32'd1);
    check("ovf_w2_port", {27'd0, wr_port}, 32'd11);
    check("ovf_w2_data", wr_data, 32'h101);
    step();
    #1 check("ovf_w3_none", {31'd0, wr_en}, 32'd0);
    check("ovf_sticky", {31'd0, lsu_overflow}, 32'd1);
    step();

    // x0 writes are granted but never enabled
    set_in(0, 1, 5'd0, 32'h55, 0, 0, 0);
    #1 check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    set_in(0, 0, 0, 0, 1, 5'd0, 32'h66);
    #1 check("x0_alu_en", {31'd0, wr_en}, 32'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 1, 5'd7, 32'h77, 0, 0, 0);
    #1 check("x0_lsu_en", {31'd0, wr_en}, 32'd0);
    check("x0_fifo_drained", {31'd0, alu_ready}, 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1 check("x7_en", {31'd0, wr_en}, 32'd1);
    check("x7_port", {27'd0, wr_port}, 32'd7);
    check("x7_data", wr_data, 32'h77);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back scheduler for the single register-file write port. Shares that port between the ALU write-back path and the load/store unit (LSU) load-return path. The ALU side uses a valid/ready handshake. The LSU side cannot be back-pressured, so its returns are buffered in a small FIFO. The block drives the register file's write interface from registered outputs and suppresses writes to x0.

## Interface
- `LSU_DEPTH`, default 2: LSU return FIFO depth; power of two, ≥ 2.
- `STARVE_LIMIT`, default 2: consecutive denied ALU cycles before the ALU is forced a grant; range 1–7.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `hold_i`  in  1  pipeline freeze; no grants while high.
- `alu_valid_i`  in  1  ALU write-back request.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_data_i`  in  32  ALU result.
- `alu_ready_o`  out  1  ALU request accepted this cycle (combinational).
- `lsu_valid_i`  in  1  load-return push; no ready.
- `lsu_rd_i`  in  5  load destination register.
- `lsu_data_i`  in  32  load data.
- `wr_port_o`  out  5  register-file write register.
- `wr_data_o`  out  32  register-file write data.
- `ctrl_reg_wr_en_o`  out  1  register-file write enable.
- `lsu_overflow_o`  out  1  sticky flag; a load return was dropped.

## Operation
- **LSU FIFO**
  - Circular buffer of `LSU_DEPTH` entries {rd, data}.
  - Pointers have one extra wrap bit, so full and empty are distinguishable.
  - A push enters the FIFO at the edge. There is no bypass: the entry becomes eligible for a grant the following cycle.
- **Grant rule**, evaluated each cycle when `hold_i`=0:
  - `alu_force` = `alu_valid_i` && `starve_cnt` == `STARVE_LIMIT`.
  - If the FIFO is non-empty and `alu_force` is 0, the LSU head wins and the FIFO is popped.
  - Otherwise, if `alu_valid_i`=1, the ALU wins and `alu_ready_o`=1.
  - Otherwise, no grant.
- **`alu_ready_o`** = !`hold_i` && `alu_valid_i` && (FIFO empty || `alu_force`).
- **Starvation counter `starve_cnt`**, width 3:
  - Resets to 0 on an ALU handshake, or whenever `alu_valid_i`=0.
  - Increments when `alu_valid_i`=1, `alu_ready_o`=0 and `hold_i`=0, saturating at `STARVE_LIMIT`.
  - Frozen while `hold_i`=1.
- **Output stage**, updated at every edge:
  - With a grant: `wr_port_o`/`wr_data_o` take the winner's rd/data, and `ctrl_reg_wr_en_o` = (rd != 0).
  - Without a grant: `ctrl_reg_wr_en_o` = 0, and port/data hold their last values.
  - A grant to rd=0 still completes the handshake (ALU) or the pop (LSU), but no write is issued.
- **Push while full**:
  - Without a same-cycle pop, the pushed entry is dropped and `lsu_overflow_o` is set. It stays set until reset.
  - With a same-cycle pop, the push succeeds and there is no overflow.
- **`hold_i`**:
  - No pop and no ALU grant.
  - FIFO pushes continue, with the same overflow rule.
- **Reset** (asynchronous, at any time):
  - FIFO emptied; any in-flight load returns are discarded.
  - `starve_cnt`=0.
  - `wr_port_o`=0, `wr_data_o`=0, `ctrl_reg_wr_en_o`=0, `lsu_overflow_o`=0.
  - `alu_ready_o` follows its equation; it is 0 while `alu_valid_i`=0.

## Timing
- ALU: handshake in cycle N → `ctrl_reg_wr_en_o` high in cycle N+1. The register file commits the write at the next edge.
- LSU: push in cycle N → earliest grant in N+1 → `ctrl_reg_wr_en_o` high in N+2.
- Throughput: at most one write per cycle.
  - Back-to-back grants produce back-to-back write-enable cycles.
  - Grants follow the priority order above, not arrival order.
- With the ALU continuously valid and the FIFO never empty, the ALU wins at least 1 of every `STARVE_LIMIT`+1 cycles.
- `lsu_overflow_o` rises in the cycle after the dropped push.

## Test plan
1. **Reset**: assert `rst_n`=0 mid-stream with 2 FIFO entries. Required: all outputs 0 immediately. After release, FIFO empty, with no write-enable pulses until new requests arrive.
2. **ALU only**: `alu_valid_i` with rd=5, data=0xDEADBEEF in cycle N. Required: `alu_ready_o`=1 in N; in N+1, `ctrl_reg_wr_en_o`=1, `wr_port_o`=5, `wr_data_o`=0xDEADBEEF.
3. **Contention**: push LSU rd=3/0x11 in cycle 0, then hold `alu_valid_i` (rd=4/0x22) from cycle 1, with `STARVE_LIMIT`=2. Required:
   - Cycle 1: LSU granted; rd=3 written in cycle 2.
   - Cycle 2: ALU granted (FIFO empty); rd=4 written in cycle 3.
4. **Starvation**: LSU pushes every cycle from cycle 0, ALU valid from cycle 1, `STARVE_LIMIT`=2. Required:
   - ALU denied in cycles 1 and 2, granted in cycle 3.
   - Thereafter, ALU grants repeat at least every 3rd cycle.
5. **Overflow**: `hold_i`=1, then 3 pushes with `LSU_DEPTH`=2. Required:
   - The 3rd push is dropped and `lsu_overflow_o`=1 from the next cycle, sticky.
   - After `hold_i`=0, exactly 2 writes occur, in push order.
6. **x0**: ALU rd=0 and LSU rd=0 requests. Required: both handshakes/pops complete, `ctrl_reg_wr_en_o` stays 0, and a later rd=7 write proceeds normally.
